mac_row_seq: RTL and testbench
==============================

# mac_row_seq

Word-serial row sequencer for the Montgomery product datapath: computes one CIOS row T + a·B over NUM_WORDS 64-bit words by issuing one operand set per word to a downstream `mul_add` unit and chaining its high word back as the next carry. It sits directly upstream of `mul_add`, owns its operand registers, and streams result words to the MonPro accumulator. `mul_add` stays outside this block so several sequencers can share it.

## Interface
- DATA_WIDTH, 64, word width; must match `mul_add`.
- NUM_WORDS, 16, words per row (≥1).
- MUL_LATENCY, 3, register stages in `mul_add` from operand to `{c,s}`.
- clk  in  1  rising-edge clock (one clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a row; sampled only in IDLE.
- a  in  DATA_WIDTH  row scalar; captured on accepted start.
- in_valid / in_ready  in / out  1  word-input handshake.
- in_b, in_t  in  DATA_WIDTH  B[j], T[j] for the current word.
- mul_x, mul_y, mul_z, mul_last_c  out  DATA_WIDTH  registered operands to `mul_add`.
- mul_s, mul_c  in  DATA_WIDTH  `mul_add` low/high result.
- out_valid / out_ready  out / in  1  result-word handshake.
- out_word  out  DATA_WIDTH  result word; out_last  out  1  marks final word of the row.
- busy  out  1  high outside IDLE; done  out  1  one-cycle pulse at row end.
- carry_out  out  DATA_WIDTH  final carry, valid from done until next start.

## Operation
- States: IDLE, ISSUE, WAIT, OUT, FLUSH.
- IDLE: busy=0; on start, latch a, carry←0, j←0 → ISSUE.
- ISSUE: in_ready=1; on in_valid, register mul_x=a, mul_y=in_b, mul_z=in_t, mul_last_c=carry; load wait counter with MUL_LATENCY → WAIT.
- WAIT: decrement each cycle; at zero, capture out_word←mul_s, carry←mul_c → OUT.
- OUT: out_valid=1, out_last=1 only when j=NUM_WORDS-1 and macro undefined; on out_ready: if j=NUM_WORDS-1 → FLUSH (macro defined) or IDLE with done (undefined); else j←j+1 → ISSUE.
- FLUSH: out_word=carry, out_valid=1, out_last=1; on out_ready → IDLE, done pulses.
- Operand registers hold their values from issue until the next issue; `mul_add` samples z/last_c combinationally at its second stage and depends on this.
- Arithmetic: per word {mul_c,mul_s} = a·B[j] + T[j] + carry; never overflows 2·DATA_WIDTH bits.
- start while busy ignored. in_valid outside ISSUE ignored (in_ready=0).
- Reset: all outputs and registers 0, state IDLE, including mid-row; no partial words emitted after release.

## Timing
- Issue at edge E0; result captured at E0+MUL_LATENCY+1; out_valid asserted in the cycle after.
- Minimum word period with in_valid and out_ready held high: MUL_LATENCY+3 cycles (6 at default).
- out_word/out_last stable while out_valid=1 and out_ready=0.
- done asserted in the cycle after the final output handshake; carry_out updated on same edge.

## Configuration
- `MAC_ROW_CARRY_WORD_EN` defined: row emits NUM_WORDS+1 words, the last being the final carry via FLUSH.
- Undefined: FLUSH state absent, row emits NUM_WORDS words, out_last on word NUM_WORDS-1; final carry only on carry_out.

## Structure
- Shared package `mac_row_pkg`: state enum, DATA_WIDTH default, counter width derived from MUL_LATENCY.
- No sub-module; wait counter and word index inline. `mul_add` instantiated by the parent MonPro.

## Test plan
Bench: NUM_WORDS=4, behavioural `mul_add` model with MUL_LATENCY=3.
- Reset asserted → all outputs 0, busy=0, state IDLE.
- a=2, B=[1,2,3,4], T=0, macro on → outputs 2,4,6,8,0 with out_last on 0; done one cycle after; carry_out=0.
- a=B[j]=T[j]=0xFFFF_FFFF_FFFF_FFFF → outputs 0, all-ones ×3, all-ones (carry); carry_out=all-ones.
- Same as previous with macro off → 4 words, out_last on word 3, carry_out=all-ones.
- out_ready low 10 cycles on word 1 → out_word held constant, in_ready stays 0, mul_* operands unchanged.
- rst_n low during WAIT of word 2 → all outputs 0 immediately; after release, new start with a=1, B=[5,6,7,8], T=[1,1,1,1] yields 6,7,8,9,0.

Source files
------------

// File: rtl/mac_row_pkg.sv
// Shared types and defaults for the CIOS row sequencer.
// The optional final-carry output word is enabled by MAC_ROW_CARRY_WORD_EN.
package mac_row_pkg;

  localparam int DATA_WIDTH_DEF  = 64;
  localparam int NUM_WORDS_DEF   = 16;
  localparam int MUL_LATENCY_DEF = 3;

`ifdef MAC_ROW_CARRY_WORD_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, FLUSH} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT} state_t;
`endif

  // Width of a down-counter that is loaded with lat and counts to zero.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mac_row_seq.sv
// Word-serial CIOS row sequencer: streams T + a*B through an external mul_add
// unit one word at a time, chaining the high result word back as carry.
// Optional: MAC_ROW_CARRY_WORD_EN appends the final carry as an extra output word.
module mac_row_seq
  import mac_row_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_WORDS   = NUM_WORDS_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_t,
  output logic [DATA_WIDTH-1:0] mul_x,
  output logic [DATA_WIDTH-1:0] mul_y,
  output logic [DATA_WIDTH-1:0] mul_z,
  output logic [DATA_WIDTH-1:0] mul_last_c,
  input  logic [DATA_WIDTH-1:0] mul_s,
  input  logic [DATA_WIDTH-1:0] mul_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_word,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] carry_out
);

  localparam int CW = cnt_width(MUL_LATENCY);
  localparam int JW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [JW-1:0] J_LAST   = JW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY);

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] a_q, carry_q, out_word_q;
  logic [JW-1:0]         j_q;
  logic [CW-1:0]         cnt_q;
  logic                  done_q;
  logic                  at_last;
  logic                  row_done;

  assign out_word = out_word_q;
  assign done     = done_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    row_done  = 1'b0;
    at_last   = (j_q == J_LAST);
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ISSUE;
      end
      ISSUE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = WAIT;
      end
      WAIT: if (cnt_q == '0) state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
`ifndef MAC_ROW_CARRY_WORD_EN
        out_last = at_last;
`endif
        if (out_ready) begin
          if (!at_last) state_nx = ISSUE;
          else begin
`ifdef MAC_ROW_CARRY_WORD_EN
            state_nx = FLUSH;
`else
            state_nx = IDLE;
            row_done = 1'b1;
`endif
          end
        end
      end
`ifdef MAC_ROW_CARRY_WORD_EN
      FLUSH: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
          row_done = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Operand, carry, word index, wait counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      carry_q    <= '0;
      out_word_q <= '0;
      j_q        <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      mul_x      <= '0;
      mul_y      <= '0;
      mul_z      <= '0;
      mul_last_c <= '0;
      carry_out  <= '0;
    end else begin
      done_q <= row_done;
      case (state)
        IDLE: if (start) begin
          a_q     <= a;
          carry_q <= '0;
          j_q     <= '0;
        end
        // Operands stay put until the next issue; mul_add reads z/last_c late.
        ISSUE: if (in_valid) begin
          mul_x      <= a_q;
          mul_y      <= in_b;
          mul_z      <= in_t;
          mul_last_c <= carry_q;
          cnt_q      <= CNT_LOAD;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            out_word_q <= mul_s;
            carry_q    <= mul_c;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        OUT: if (out_ready) begin
          if (!at_last) j_q <= j_q + JW'(1);
`ifdef MAC_ROW_CARRY_WORD_EN
          else out_word_q <= carry_q;
`endif
        end
        default: ;
      endcase
      if (row_done) carry_out <= carry_q;
    end
  end

endmodule

// File: tb/tb_mac_row_seq.sv
// Self-checking bench for mac_row_seq with a behavioural 3-stage mul_add.
module tb_mac_row_seq;

  localparam int NW  = 4;
  localparam int LAT = 3;
`ifdef MAC_ROW_CARRY_WORD_EN
  localparam int N_OUT = NW + 1;
`else
  localparam int N_OUT = NW;
`endif
  localparam logic [63:0] M = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [63:0] a, in_b, in_t, mul_x, mul_y, mul_z, mul_last_c, mul_s, mul_c;
  logic [63:0] out_word, carry_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]         a;
    logic [NW-1:0][63:0] b;
    logic [NW-1:0][63:0] t;
    logic [NW-1:0][63:0] w;
    logic [63:0]         carry;
    int                  stall_w;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  mac_row_seq #(.DATA_WIDTH(64), .NUM_WORDS(NW), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a),
    .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b), .in_t(in_t),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z), .mul_last_c(mul_last_c),
    .mul_s(mul_s), .mul_c(mul_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
    .busy(busy), .done(done), .carry_out(carry_out)
  );

  // Behavioural mul_add: three register stages from operands to {c,s}
  logic [127:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= {64'd0, mul_x} * {64'd0, mul_y} + {64'd0, mul_z} + {64'd0, mul_last_c};
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_s = p3[63:0];
  assign mul_c = p3[127:64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " done"}, {63'd0, done}, 64'd0);
    chk({tag, " out_last"}, {63'd0, out_last}, 64'd0);
    chk({tag, " out_word"}, out_word, 64'd0);
    chk({tag, " carry_out"}, carry_out, 64'd0);
    chk({tag, " mul_x"}, mul_x, 64'd0);
    chk({tag, " mul_y"}, mul_y, 64'd0);
    chk({tag, " mul_z"}, mul_z, 64'd0);
    chk({tag, " mul_last_c"}, mul_last_c, 64'd0);
  endtask

  task automatic run_row(input vec_t r, input string tag);
    int wi, oi, cyc, stall;
    int ic[NW];
    bit in_hs, out_hs, seen;
    logic [63:0] hw, hx, hy, hz, hc, ew;
    logic hl;
    @(negedge clk);
    a = r.a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after start"}, {63'd0, busy}, 64'd1);
    wi = 0; oi = 0; cyc = 0; stall = 0; seen = 0;
    hw = '0; hx = '0; hy = '0; hz = '0; hc = '0; hl = 1'b0;
    while (oi < N_OUT && cyc < 1000) begin
      in_valid = (wi < NW);
      if (wi < NW) begin
        in_b = r.b[wi];
        in_t = r.t[wi];
      end
      in_hs = in_ready && (wi < NW);
      out_ready = 1'b0;
      out_hs = 0;
      if (out_valid) begin
        ew = (oi < NW) ? r.w[oi] : r.carry;
        if (!seen) begin
          chk($sformatf("%s word%0d", tag, oi), out_word, ew);
          chk($sformatf("%s last%0d", tag, oi), {63'd0, out_last}, {63'd0, oi == N_OUT - 1});
          seen = 1;
          hw = out_word; hl = out_last;
          hx = mul_x; hy = mul_y; hz = mul_z; hc = mul_last_c;
        end else begin
          chk({tag, " stall out_word"}, out_word, hw);
          chk({tag, " stall out_last"}, {63'd0, out_last}, {63'd0, hl});
          chk({tag, " stall in_ready"}, {63'd0, in_ready}, 64'd0);
          chk({tag, " stall mul_x"}, mul_x, hx);
          chk({tag, " stall mul_y"}, mul_y, hy);
          chk({tag, " stall mul_z"}, mul_z, hz);
          chk({tag, " stall mul_last_c"}, mul_last_c, hc);
        end
        if (oi == r.stall_w && stall < 10) stall++;
        else begin
          out_ready = 1'b1;
          out_hs = 1;
        end
      end
      @(posedge clk);
      if (in_hs) begin
        ic[wi] = cyc;
        wi++;
      end
      if (out_hs) begin
        oi++;
        seen = 0;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 1000) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d words expected %0d", tag, oi, N_OUT);
    end
    // Now in the cycle right after the final output handshake.
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " carry_out"}, carry_out, r.carry);
    chk({tag, " busy idle"}, {63'd0, busy}, 64'd0);
    if (r.stall_w != 0)
      chk({tag, " word period"}, 64'(ic[1] - ic[0]), 64'(LAT + 3));
    @(negedge clk);
    chk({tag, " done pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int wi, cyc;
    bit hs;
    // Packed arrays are written msb-first: {[3],[2],[1],[0]}.
    vecs[0].a = 64'd2;
    vecs[0].b = {64'd4, 64'd3, 64'd2, 64'd1};
    vecs[0].t = '0;
    vecs[0].w = {64'd8, 64'd6, 64'd4, 64'd2};
    vecs[0].carry = 64'd0;
    vecs[0].stall_w = -1;
    // 3*M+5 = 3*2^64+2 ; 3*M+3 = 3*2^64 ; 0+3 ; 3*1
    vecs[1].a = 64'd3;
    vecs[1].b = {64'd1, 64'd0, M, M};
    vecs[1].t = {64'd0, 64'd0, 64'd0, 64'd5};
    vecs[1].w = {64'd3, 64'd3, 64'd0, 64'd2};
    vecs[1].carry = 64'd0;
    vecs[1].stall_w = 1;
    // M*M+M = M*2^64 ; M*M+M+M = M*2^64+M
    vecs[2].a = M;
    vecs[2].b = {M, M, M, M};
    vecs[2].t = {M, M, M, M};
    vecs[2].w = {M, M, M, 64'd0};
    vecs[2].carry = M;
    vecs[2].stall_w = -1;
    vecs[3].a = 64'd1;
    vecs[3].b = {64'd8, 64'd7, 64'd6, 64'd5};
    vecs[3].t = {64'd1, 64'd1, 64'd1, 64'd1};
    vecs[3].w = {64'd9, 64'd8, 64'd7, 64'd6};
    vecs[3].carry = 64'd0;
    vecs[3].stall_w = -1;

    rst_n = 1'b0; start = 1'b0; a = '0; in_valid = 1'b0; in_b = '0; in_t = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) run_row(vecs[v], $sformatf("row%0d", v));

    // Abort a row while word 2 is in flight.
    @(negedge clk);
    a = vecs[0].a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    wi = 0; cyc = 0;
    while (wi < 3 && cyc < 200) begin
      in_valid = 1'b1;
      in_b = vecs[0].b[wi];
      in_t = vecs[0].t[wi];
      hs = in_ready;
      @(posedge clk);
      if (hs) wi++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL abort timeout: got %0d issues expected 3", wi);
    end
    chk("abort in WAIT busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid-row reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post-reset out_valid", {63'd0, out_valid}, 64'd0);
      chk("post-reset busy", {63'd0, busy}, 64'd0);
    end

    run_row(vecs[3], "row3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
